// File: rtl/xlr8_pwcapture.sv
// RC pulse-width capture: times up to NUM_CHANS servo pulses in microseconds and forwards each width to the servo block.
// Optional range filter: define XLR8_PWCAP_RANGE_EN to forward only widths within MIN_PW..MAX_PW.

module xlr8_pwcapture #(
    parameter int          NUM_CHANS  = 4,
    parameter logic [4:0]  BASE_IDX   = 5'd0,
    parameter logic [14:0] TIMEOUT_US = 15'd25000,
    parameter logic [11:0] MIN_PW     = 12'd500,
    parameter logic [11:0] MAX_PW     = 12'd2500
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en1mhz,
    input  logic [NUM_CHANS-1:0] pins_in,
    input  logic [NUM_CHANS-1:0] cap_en,
    output logic [4:0]           priv_index,
    output logic                 priv_wr_pw,
    output logic [15:0]          priv_pw,
    output logic [NUM_CHANS-1:0] cap_valid
);

    localparam int          IW   = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1;
    localparam logic [0:0]  IDLE = 1'b0;
    localparam logic [0:0]  HIGH = 1'b1;
    localparam logic [11:0] WMAX = 12'hFFF;

    logic [NUM_CHANS-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_CHANS-1:0] rise_q, fall_q;
    logic [NUM_CHANS-1:0] state_q, state_d;
    logic [NUM_CHANS-1:0] pending_q, pending_d;
    logic [NUM_CHANS-1:0] valid_q, valid_d;
    logic [NUM_CHANS-1:0] inRange, req;
    logic [11:0]          width_q [NUM_CHANS];
    logic [11:0]          width_d [NUM_CHANS];
    logic [11:0]          widthCnt [NUM_CHANS];
    logic [11:0]          latch_q [NUM_CHANS];
    logic [11:0]          latch_d [NUM_CHANS];
    logic [14:0]          timer_q [NUM_CHANS];
    logic [14:0]          timer_d [NUM_CHANS];
    logic [IW-1:0]        lastPtr_q, lastPtr_d, grantIdx;
    logic                 grantHit;
    logic                 wr_q, wr_d;
    logic [4:0]           index_q, index_d;
    logic [15:0]          pw_q, pw_d;

    always_comb begin
        for (int i = 0; i < NUM_CHANS; i++) begin
            widthCnt[i] = (en1mhz && width_q[i] != WMAX) ? width_q[i] + 12'd1 : width_q[i];
        end
    end

`ifdef XLR8_PWCAP_RANGE_EN
    always_comb begin
        inRange = '0;
        for (int i = 0; i < NUM_CHANS; i++) begin
            inRange[i] = (widthCnt[i] >= MIN_PW) && (widthCnt[i] <= MAX_PW);
        end
    end
`else
    logic [23:0] unusedRangeBounds;
    assign unusedRangeBounds = {MIN_PW, MAX_PW};
    assign inRange = '1;
`endif

    // Round-robin: lowest requester above the last-served channel wins, otherwise wrap to the lowest overall.
    assign req = pending_q & cap_en;

    always_comb begin
        grantHit = 1'b0;
        grantIdx = '0;
        for (int j = NUM_CHANS - 1; j >= 0; j--) begin
            if (req[j] && IW'(j) <= lastPtr_q) begin
                grantHit = 1'b1;
                grantIdx = IW'(j);
            end
        end
        for (int j = NUM_CHANS - 1; j >= 0; j--) begin
            if (req[j] && IW'(j) > lastPtr_q) begin
                grantHit = 1'b1;
                grantIdx = IW'(j);
            end
        end
    end

    always_comb begin
        wr_d      = grantHit;
        index_d   = index_q;
        pw_d      = pw_q;
        lastPtr_d = lastPtr_q;
        if (grantHit) begin
            index_d   = BASE_IDX + 5'(grantIdx);
            pw_d      = {4'h0, latch_q[grantIdx]};
            lastPtr_d = grantIdx;
        end
    end

    // A capture on the same cycle as its service wins: the fresh width stays pending for a later write.
    always_comb begin
        for (int i = 0; i < NUM_CHANS; i++) begin
            state_d[i]   = state_q[i];
            width_d[i]   = width_q[i];
            latch_d[i]   = latch_q[i];
            pending_d[i] = pending_q[i];
            timer_d[i]   = timer_q[i];
            valid_d[i]   = valid_q[i];
            if (grantHit && grantIdx == IW'(i)) begin
                pending_d[i] = 1'b0;
            end
            if (en1mhz && timer_q[i] != TIMEOUT_US) begin
                timer_d[i] = timer_q[i] + 15'd1;
            end
            if (timer_d[i] == TIMEOUT_US) begin
                valid_d[i] = 1'b0;
            end
            if (!cap_en[i]) begin
                state_d[i]   = IDLE;
                width_d[i]   = '0;
                latch_d[i]   = '0;
                pending_d[i] = 1'b0;
                timer_d[i]   = '0;
                valid_d[i]   = 1'b0;
            end else if (state_q[i] == IDLE) begin
                if (rise_q[i]) begin
                    state_d[i] = HIGH;
                    width_d[i] = '0;
                end
            end else begin
                width_d[i] = widthCnt[i];
                if (fall_q[i]) begin
                    state_d[i] = IDLE;
                    if (widthCnt[i] != WMAX && inRange[i]) begin
                        latch_d[i]   = widthCnt[i];
                        pending_d[i] = 1'b1;
                        timer_d[i]   = '0;
                        valid_d[i]   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            state_q   <= '0;
            pending_q <= '0;
            valid_q   <= '0;
            lastPtr_q <= IW'(NUM_CHANS - 1);
            wr_q      <= 1'b0;
            index_q   <= 5'd0;
            pw_q      <= 16'h0;
            for (int i = 0; i < NUM_CHANS; i++) begin
                width_q[i] <= '0;
                latch_q[i] <= '0;
                timer_q[i] <= '0;
            end
        end else begin
            sync1_q   <= pins_in;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            rise_q    <= sync2_q & ~sync3_q;
            fall_q    <= ~sync2_q & sync3_q;
            state_q   <= state_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            lastPtr_q <= lastPtr_d;
            wr_q      <= wr_d;
            index_q   <= index_d;
            pw_q      <= pw_d;
            for (int i = 0; i < NUM_CHANS; i++) begin
                width_q[i] <= width_d[i];
                latch_q[i] <= latch_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    assign priv_wr_pw = wr_q;
    assign priv_index = index_q;
    assign priv_pw    = pw_q;
    assign cap_valid  = valid_q;

endmodule

// File: tb/tb_xlr8_pwcapture.sv
// Self-checking bench for xlr8_pwcapture: a pin-level model predicts every write and cap_valid each cycle,
// while directed scenarios pin the model with hand-computed widths, orders and latencies.

module tb_xlr8_pwcapture;

    localparam int NUM     = 4;
    localparam int TIMEOUT = 25000;
    localparam int SAT     = 4095;

    logic            clk = 1'b0;
    logic            rstn;
    logic            en1mhz;
    logic [NUM-1:0]  pinsIn;
    logic [NUM-1:0]  capEn;
    logic [4:0]      privIndex;
    logic            privWrPw;
    logic [15:0]     privPw;
    logic [NUM-1:0]  capValid;

    int checks    = 0;
    int failures  = 0;
    int cycleCnt  = 0;
    bit denseMode = 1'b0;

    int logCycle[$];
    int logIdx[$];
    int logPw[$];

    bit             mPrevPin[NUM];
    bit             mInPulse[NUM];
    int             mCount[NUM];
    int             mSched[NUM];
    int             mSchedW[NUM];
    bit             mPend[NUM];
    int             mLat[NUM];
    bit             mValid[NUM];
    int             mTick[NUM];
    int             mLast;
    bit             expWr;
    int             expIdx;
    int             expPw;
    logic [NUM-1:0] expValid;

    xlr8_pwcapture #(.NUM_CHANS(NUM)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en1mhz     (en1mhz),
        .pins_in    (pinsIn),
        .cap_en     (capEn),
        .priv_index (privIndex),
        .priv_wr_pw (privWrPw),
        .priv_pw    (privPw),
        .cap_valid  (capValid)
    );

    initial forever #5 clk = ~clk;

    // en1mhz every 4th clock normally, every clock in dense mode to keep long scenarios short
    initial begin
        en1mhz = 1'b0;
        forever begin
            @(negedge clk);
            en1mhz = denseMode || ((cycleCnt + 1) % 4 == 0);
        end
    end

    function automatic bit widthAccepted(int w);
`ifdef XLR8_PWCAP_RANGE_EN
        return (w >= 500) && (w <= 2500);
`else
        return 1'b1;
`endif
    endfunction

    // Behavioural model: pulses are timed at the pin, forwarded three clocks after the falling sample,
    // then served one per clock in round-robin order starting after the last-served channel.
    always @(posedge clk) begin
        int cand;
        bit fired;
        cycleCnt++;
        if (!rstn) begin
            for (int c = 0; c < NUM; c++) begin
                mPrevPin[c] = 0; mInPulse[c] = 0; mCount[c] = 0; mSched[c] = 0; mSchedW[c] = 0;
                mPend[c] = 0; mLat[c] = 0; mValid[c] = 0; mTick[c] = 0;
            end
            mLast = NUM - 1; expWr = 0; expIdx = 0; expPw = 0;
        end else begin
            expWr = 0;
            for (int k = 1; k <= NUM; k++) begin
                cand = (mLast + k) % NUM;
                if (!expWr && mPend[cand] && capEn[cand]) begin
                    expWr = 1; expIdx = cand; expPw = mLat[cand];
                    mPend[cand] = 0; mLast = cand;
                end
            end
            for (int c = 0; c < NUM; c++) begin
                if (!capEn[c]) begin
                    mInPulse[c] = 0; mCount[c] = 0; mPend[c] = 0; mValid[c] = 0; mTick[c] = 0; mSched[c] = 0;
                end else begin
                    fired = 0;
                    if (mSched[c] > 0) begin
                        mSched[c]--;
                        if (mSched[c] == 0) begin
                            mPend[c] = 1; mLat[c] = mSchedW[c]; mValid[c] = 1; mTick[c] = 0; fired = 1;
                        end
                    end
                    if (!fired && en1mhz && mTick[c] < TIMEOUT) begin
                        mTick[c]++;
                        if (mTick[c] == TIMEOUT) mValid[c] = 0;
                    end
                    if (pinsIn[c] && !mPrevPin[c]) begin
                        mInPulse[c] = 1; mCount[c] = 0;
                    end
                    if (pinsIn[c] && mInPulse[c] && en1mhz && mCount[c] < SAT) mCount[c]++;
                    if (!pinsIn[c] && mPrevPin[c] && mInPulse[c]) begin
                        if (mCount[c] < SAT && widthAccepted(mCount[c])) begin
                            mSched[c] = 3; mSchedW[c] = mCount[c];
                        end
                        mInPulse[c] = 0;
                    end
                end
                mPrevPin[c] = pinsIn[c];
            end
        end
        for (int c = 0; c < NUM; c++) expValid[c] = mValid[c];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-low-phase; also records every observed write.
    always @(negedge clk) begin
        #2;
        if (!rstn) begin
            checkOutput("rstWr", privWrPw, 0);
            checkOutput("rstIdx", privIndex, 0);
            checkOutput("rstPw", privPw, 0);
            checkOutput("rstValid", capValid, 0);
        end else begin
            checkOutput("cycWr", privWrPw, expWr);
            checkOutput("cycIdx", privIndex, expIdx);
            checkOutput("cycPw", privPw, expPw);
            checkOutput("cycValid", capValid, expValid);
        end
        if (privWrPw) begin
            logCycle.push_back(cycleCnt);
            logIdx.push_back(privIndex);
            logPw.push_back(privPw);
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one pulse on channel ch lasting highCycles clocks; returns the first edge that samples it low.
    task automatic applyStimulus(input int ch, input int highCycles, output int fallEdge);
        pinsIn[ch] = 1'b1;
        waitCycles(highCycles);
        pinsIn[ch] = 1'b0;
        fallEdge = cycleCnt + 1;
    endtask

    task automatic checkWrite(input string name, input int pos, input int eIdx, input int ePw, input int eCycle);
        if (pos < logIdx.size()) begin
            checkOutput({name, "Idx"}, logIdx[pos], eIdx);
            checkOutput({name, "Pw"}, logPw[pos], ePw);
            if (eCycle >= 0) checkOutput({name, "Cycle"}, logCycle[pos], eCycle);
        end else begin
            checkOutput({name, "Present"}, logIdx.size(), pos + 1);
        end
    endtask

    initial begin
        int mark;
        int fallEdge;
        int fellAt;
        rstn   = 1'b0;
        pinsIn = '0;
        capEn  = '1;
        waitCycles(3);
        checkOutput("resetWr", privWrPw, 0);
        checkOutput("resetIdx", privIndex, 0);
        checkOutput("resetPw", privPw, 0);
        checkOutput("resetValid", capValid, 0);
        rstn = 1'b1;
        waitCycles(5);

        // Contention: ch3..ch0 rise staggered, all fall together with widths 1600/1400/1200/1000
        mark = logIdx.size();
        pinsIn[3] = 1'b1; waitCycles(800);
        pinsIn[2] = 1'b1; waitCycles(800);
        pinsIn[1] = 1'b1; waitCycles(800);
        pinsIn[0] = 1'b1; waitCycles(4000);
        pinsIn = '0;
        fallEdge = cycleCnt + 1;
        waitCycles(20);
        checkOutput("contentionCount", logIdx.size() - mark, 4);
        for (int k = 0; k < 4; k++) checkWrite("contention", mark + k, k, 1000 + 200 * k, fallEdge + 4 + k);

        // Single pulse on ch0: 1500 ticks, written 4 clocks after the falling sample
        mark = logIdx.size();
        applyStimulus(0, 6000, fallEdge);
        waitCycles(20);
        checkOutput("singleCount", logIdx.size() - mark, 1);
        checkWrite("single", mark, 0, 1500, fallEdge + 4);
        checkOutput("singleValid", capValid[0], 1);

        // Saturation on ch1: over-long pulse dropped, next pulse written
        denseMode = 1'b1;
        waitCycles(5);
        mark = logIdx.size();
        applyStimulus(1, 5000, fallEdge);
        waitCycles(20);
        checkOutput("satCount", logIdx.size() - mark, 0);
        checkOutput("satValidKept", capValid[1], 1);
        mark = logIdx.size();
        applyStimulus(1, 1500, fallEdge);
        waitCycles(20);
        checkWrite("afterSat", mark, 1, 1500, fallEdge + 4);

        // Range behaviour on ch1
        mark = logIdx.size();
`ifdef XLR8_PWCAP_RANGE_EN
        applyStimulus(1, 300, fallEdge);
        waitCycles(20);
        applyStimulus(1, 2600, fallEdge);
        waitCycles(20);
        checkOutput("rangeRejectCount", logIdx.size() - mark, 0);
        applyStimulus(1, 2500, fallEdge);
        waitCycles(20);
        checkWrite("rangeMax", mark, 1, 2500, fallEdge + 4);
`else
        applyStimulus(1, 300, fallEdge);
        waitCycles(20);
        checkWrite("rangeOff", mark, 1, 300, fallEdge + 4);
`endif

        // Timeout on ch2: forwarded 3 clocks after the fall, then 25000 ticks at one tick per clock
        applyStimulus(2, 800, fallEdge);
        waitCycles(10);
        checkOutput("timeoutValidSet", capValid[2], 1);
        fellAt = -1;
        for (int n = 0; n < 26000; n++) begin
            @(negedge clk);
            if (capValid[2] == 1'b0) begin
                fellAt = cycleCnt;
                break;
            end
        end
        checkOutput("timeoutFall", fellAt - fallEdge, 3 + TIMEOUT);

        // Disable ch3 mid-pulse: nothing forwarded
        mark = logIdx.size();
        pinsIn[3] = 1'b1; waitCycles(100);
        capEn[3] = 1'b0; waitCycles(10);
        pinsIn[3] = 1'b0; waitCycles(10);
        capEn[3] = 1'b1; waitCycles(20);
        checkOutput("disableCount", logIdx.size() - mark, 0);
        checkOutput("disableValid", capValid[3], 0);

        // Reset while ch0 is pending, just before its write
        mark = logIdx.size();
        applyStimulus(0, 200, fallEdge);
        waitCycles(3);
        rstn = 1'b0;
        waitCycles(5);
        rstn = 1'b1;
        waitCycles(50);
        checkOutput("resetDropCount", logIdx.size() - mark, 0);
        checkOutput("postResetWr", privWrPw, 0);
        checkOutput("postResetIdx", privIndex, 0);
        checkOutput("postResetPw", privPw, 0);
        checkOutput("postResetValid", capValid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
